// File: rtl/streetlight_zone_scheduler.sv
// Purpose : zone sequencer for N street lamps on a shared feed; filters the day sensor,
//           stagger-starts lamps into DIM at dusk and grants BRIGHT round-robin under a budget.
// Latency : night flips on the DAY_FILT-th differing edge; ramp one lamp per edge; BRIGHT grant 1 cycle.
// Backpressure: none; requests beyond MAX_BRIGHT wait and raise a registered 'denied' flag.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   day          raw ambient sensor (1 = daylight)
//   veh_detect   per-lamp vehicle present
//   lamp_mode    lamp i at [2i+1:2i]: 00 OFF, 01 DIM, 10 BRIGHT
//   bright_cnt   number of lamps currently BRIGHT
//   night        filtered night indication
//   denied       a BRIGHT request was refused because the budget was full
module streetlight_zone_scheduler #(
    parameter int N_LAMPS    = 4,
    parameter int MAX_BRIGHT = 2,
    parameter int HOLD_CYC   = 16,
    parameter int DAY_FILT   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         day,
    input  logic [N_LAMPS-1:0]           veh_detect,
    output logic [2*N_LAMPS-1:0]         lamp_mode,
    output logic [$clog2(N_LAMPS+1)-1:0] bright_cnt,
    output logic                         night,
    output logic                         denied
);
    localparam int CW = $clog2(N_LAMPS + 1);
    localparam int PW = (N_LAMPS > 1) ? $clog2(N_LAMPS) : 1;
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int FW = $clog2(DAY_FILT + 1);

    localparam logic [1:0] M_OFF    = 2'b00;
    localparam logic [1:0] M_DIM    = 2'b01;
    localparam logic [1:0] M_BRIGHT = 2'b10;

    typedef enum logic [1:0] {S_DAY, S_RAMP, S_NIGHT} state_t;

    state_t                      state;
    logic                        day_f;
    logic [FW-1:0]               filt_cnt;
    logic [PW-1:0]               ramp_idx;
    logic [PW-1:0]               rr_ptr;
    logic [N_LAMPS-1:0][HW-1:0]  hold;

    logic                        filt_hit;
    logic                        day_f_nxt;
    logic [N_LAMPS-1:0]          req;
    logic                        any_req;
    logic                        grant_vld;
    logic                        grant_ok;
    logic [PW-1:0]               grant_idx;
    logic [2*N_LAMPS-1:0]        mode_n;
    logic [N_LAMPS-1:0][HW-1:0]  hold_n;
    logic [CW-1:0]               cnt_n;

    function automatic int wrap(input int v);
        return (v >= N_LAMPS) ? v - N_LAMPS : v;
    endfunction

    // The filtered day value is used at the edge it flips, so night, the ramp start
    // and the all-OFF at dawn all land on the same edge.
    assign filt_hit  = (day != day_f) && (filt_cnt == FW'(DAY_FILT - 1));
    assign day_f_nxt = filt_hit ? day : day_f;

    // Arbitration and hold bookkeeping, evaluated from registered state only.
    always_comb begin
        req       = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        mode_n    = lamp_mode;
        hold_n    = hold;
        cnt_n     = '0;
        for (int i = 0; i < N_LAMPS; i++) begin
            req[i] = (lamp_mode[2*i +: 2] == M_DIM) && veh_detect[i];
        end
        any_req = |req;
        for (int k = 0; k < N_LAMPS; k++) begin
            if (!grant_vld && req[wrap(int'(rr_ptr) + k)]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(wrap(int'(rr_ptr) + k));
            end
        end
        // Budget check uses the registered count, so a slot freed this cycle is not reused until next.
        grant_ok = grant_vld && (bright_cnt < CW'(MAX_BRIGHT));
        for (int i = 0; i < N_LAMPS; i++) begin
            if (lamp_mode[2*i +: 2] == M_BRIGHT) begin
                if (veh_detect[i]) begin
                    hold_n[i] = HW'(HOLD_CYC);
                end else if (hold[i] == HW'(1)) begin
                    mode_n[2*i +: 2] = M_DIM;
                    hold_n[i]        = '0;
                end else begin
                    hold_n[i] = hold[i] - HW'(1);
                end
            end
        end
        if (grant_ok) begin
            mode_n[{grant_idx, 1'b0} +: 2] = M_BRIGHT;
            hold_n[grant_idx]              = HW'(HOLD_CYC);
        end
        for (int i = 0; i < N_LAMPS; i++) begin
            if (mode_n[2*i +: 2] == M_BRIGHT) begin
                cnt_n = cnt_n + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_DAY;
            day_f      <= 1'b1;
            filt_cnt   <= '0;
            ramp_idx   <= '0;
            rr_ptr     <= '0;
            hold       <= '0;
            lamp_mode  <= '0;
            bright_cnt <= '0;
            night      <= 1'b0;
            denied     <= 1'b0;
        end else begin
            day_f  <= day_f_nxt;
            night  <= ~day_f_nxt;
            denied <= 1'b0;
            if ((day == day_f) || filt_hit) begin
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end

            case (state)
                S_DAY: begin
                    lamp_mode  <= {N_LAMPS{M_OFF}};
                    bright_cnt <= '0;
                    hold       <= '0;
                    if (!day_f_nxt) begin
                        state    <= S_RAMP;
                        ramp_idx <= '0;
                    end
                end
                S_RAMP: begin
                    if (day_f_nxt) begin
                        state      <= S_DAY;
                        lamp_mode  <= {N_LAMPS{M_OFF}};
                        bright_cnt <= '0;
                        hold       <= '0;
                    end else begin
                        lamp_mode[{ramp_idx, 1'b0} +: 2] <= M_DIM;
                        ramp_idx <= ramp_idx + PW'(1);
                        if (ramp_idx == PW'(N_LAMPS - 1)) begin
                            state <= S_NIGHT;
                        end
                    end
                end
                S_NIGHT: begin
                    if (day_f_nxt) begin
                        state      <= S_DAY;
                        lamp_mode  <= {N_LAMPS{M_OFF}};
                        bright_cnt <= '0;
                        hold       <= '0;
                    end else begin
                        lamp_mode  <= mode_n;
                        hold       <= hold_n;
                        bright_cnt <= cnt_n;
                        // Only a full budget counts as a refusal; waiting for the rr turn does not.
                        denied     <= any_req && (bright_cnt == CW'(MAX_BRIGHT));
                        if (grant_ok) begin
                            rr_ptr <= PW'(wrap(int'(grant_idx) + 1));
                        end
                    end
                end
                default: begin
                    state <= S_DAY;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_streetlight_zone_scheduler.sv
module tb_streetlight_zone_scheduler;
    logic       clk;
    logic       rst_n;
    logic       day;
    logic [3:0] veh_detect;
    logic [7:0] lamp_mode;
    logic [2:0] bright_cnt;
    logic       night;
    logic       denied;

    int n_assert = 0;
    int n_fail   = 0;

    streetlight_zone_scheduler #(
        .N_LAMPS(4), .MAX_BRIGHT(2), .HOLD_CYC(16), .DAY_FILT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .day(day), .veh_detect(veh_detect),
        .lamp_mode(lamp_mode), .bright_cnt(bright_cnt), .night(night), .denied(denied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        day        = 1'b1;
        veh_detect = 4'h0;
        #2;
        chk("rst_mode",   32'(lamp_mode), 32'h00);
        chk("rst_cnt",    32'(bright_cnt), 32'd0);
        chk("rst_night",  32'(night), 32'd0);
        chk("rst_denied", 32'(denied), 32'd0);
        #10 rst_n = 1'b1;

        // Daylight: everything stays off.
        for (int i = 0; i < 50; i++) begin
            step();
            chk("day_denied", 32'(denied), 32'd0);
        end
        chk("day_mode",  32'(lamp_mode), 32'h00);
        chk("day_night", 32'(night), 32'd0);

        // Dusk: night after 8 edges, then one lamp DIM per edge.
        day = 1'b0;
        repeat (7) step();
        chk("dusk_night7", 32'(night), 32'd0);
        step();
        chk("dusk_night8", 32'(night), 32'd1);
        chk("dusk_mode8",  32'(lamp_mode), 32'h00);
        step();
        chk("ramp_l0", 32'(lamp_mode), 32'h01);
        step();
        chk("ramp_l1", 32'(lamp_mode), 32'h05);
        step();
        chk("ramp_l2", 32'(lamp_mode), 32'h15);
        step();
        chk("ramp_l3", 32'(lamp_mode), 32'h55);

        // 7-cycle day glitch is filtered out.
        day = 1'b1;
        repeat (7) step();
        day = 1'b0;
        step();
        step();
        chk("glitch_night", 32'(night), 32'd1);
        chk("glitch_mode",  32'(lamp_mode), 32'h55);
        chk("glitch_cnt",   32'(bright_cnt), 32'd0);

        // All lamps request: lamp0 then lamp1 granted, then budget full.
        veh_detect = 4'hF;
        step();
        chk("grant_l0_mode", 32'(lamp_mode), 32'h56);
        chk("grant_l0_cnt",  32'(bright_cnt), 32'd1);
        step();
        chk("grant_l1_mode", 32'(lamp_mode), 32'h5A);
        chk("grant_l1_cnt",  32'(bright_cnt), 32'd2);
        chk("grant_l1_den",  32'(denied), 32'd0);
        step();
        chk("full_mode", 32'(lamp_mode), 32'h5A);
        chk("full_den",  32'(denied), 32'd1);
        chk("full_cnt",  32'(bright_cnt), 32'd2);

        // Lamp0 hold: veh low 9 cycles, 1-cycle pulse reloads, then 16 cycles to DIM.
        veh_detect = 4'hE;
        repeat (9) step();
        chk("hold_pre_pulse", 32'(lamp_mode), 32'h5A);
        veh_detect = 4'hF;
        step();
        veh_detect = 4'hE;
        repeat (15) step();
        chk("hold_15", 32'(lamp_mode), 32'h5A);
        step();
        chk("hold_16_mode", 32'(lamp_mode), 32'h59);
        chk("hold_16_cnt",  32'(bright_cnt), 32'd1);
        chk("hold_16_den",  32'(denied), 32'd1);

        // Freed slot goes to lamp2 (rr pointer at 2) one cycle later.
        step();
        chk("reuse_mode", 32'(lamp_mode), 32'h69);
        chk("reuse_cnt",  32'(bright_cnt), 32'd2);
        chk("reuse_den",  32'(denied), 32'd0);

        // Lamps 1,2 release together; lamps 0,3 contend: lamp3 first, then wrap to lamp0.
        veh_detect = 4'h9;
        repeat (15) step();
        chk("rel_pre_mode", 32'(lamp_mode), 32'h69);
        chk("rel_pre_den",  32'(denied), 32'd1);
        step();
        chk("rel_mode", 32'(lamp_mode), 32'h55);
        chk("rel_cnt",  32'(bright_cnt), 32'd0);
        step();
        chk("wrap_l3_mode", 32'(lamp_mode), 32'h95);
        chk("wrap_l3_cnt",  32'(bright_cnt), 32'd1);
        chk("wrap_l3_den",  32'(denied), 32'd0);
        step();
        chk("wrap_l0_mode", 32'(lamp_mode), 32'h96);
        chk("wrap_l0_cnt",  32'(bright_cnt), 32'd2);

        // Dawn with two lamps BRIGHT: all OFF on the filter edge.
        day = 1'b1;
        repeat (7) step();
        chk("dawn7_mode",  32'(lamp_mode), 32'h96);
        chk("dawn7_night", 32'(night), 32'd1);
        step();
        chk("dawn8_mode",  32'(lamp_mode), 32'h00);
        chk("dawn8_cnt",   32'(bright_cnt), 32'd0);
        chk("dawn8_night", 32'(night), 32'd0);

        // Reset asserted in the middle of the ramp.
        veh_detect = 4'h0;
        day = 1'b0;
        repeat (8) step();
        chk("ramp2_night", 32'(night), 32'd1);
        step();
        step();
        chk("ramp2_mode", 32'(lamp_mode), 32'h05);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mode",  32'(lamp_mode), 32'h00);
        chk("midrst_night", 32'(night), 32'd0);
        chk("midrst_cnt",   32'(bright_cnt), 32'd0);
        day = 1'b1;
        #3 rst_n = 1'b1;
        repeat (3) step();
        chk("postrst_mode",  32'(lamp_mode), 32'h00);
        chk("postrst_night", 32'(night), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
